// File: rtl/x_accumulate.sv
// Consumer end of the X-convolution operand stream: multiplies NUM_TERMS (a, b) pairs,
// accumulates a signed Gx sum, checks calc_done alignment and publishes sum and magnitude.
module x_accumulate #(
  parameter int NUM_TERMS = 6,
  parameter int ACC_W     = 13,
  parameter int OUT_W     = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    calc_enable,
  input  logic [4:0]              a,
  input  logic [4:0]              b,
  input  logic                    calc_done,
  output logic signed [ACC_W-1:0] sum,
  output logic [OUT_W-1:0]        magnitude,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    seq_error
);

  // state | meaning
  // IDLE  | waiting for calc_enable; last result held on sum/magnitude
  // ACCUM | one product added per cycle, NUM_TERMS cycles
  // CHECK | selector DONE cycle; publish on calc_done, else flag seq_error
  // OUT   | result_valid pulse
  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, OUT} state_t;

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);
  localparam logic [ACC_W:0] MAG_MAX = (ACC_W + 1)'((1 << OUT_W) - 1);

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic signed [10:0]      prod;
  logic signed [ACC_W:0]   acc_x;
  logic [ACC_W:0]          acc_abs;
  logic [OUT_W-1:0]        mag_sat;

  // b is zero-extended so it stays non-negative in the signed multiply
  assign prod = $signed(a) * $signed({1'b0, b});

  // one extra bit so |-2^(ACC_W-1)| is representable before clamping
  assign acc_x   = {acc[ACC_W-1], acc};
  assign acc_abs = acc_x[ACC_W] ? $unsigned(-acc_x) : $unsigned(acc_x);
  assign mag_sat = (acc_abs > MAG_MAX) ? OUT_W'(MAG_MAX) : acc_abs[OUT_W-1:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (calc_enable) state_nxt = ACCUM;
      ACCUM: begin
        if (calc_done)               state_nxt = IDLE;
        else if (count == LAST_TERM) state_nxt = CHECK;
      end
      CHECK: state_nxt = calc_done ? OUT : IDLE;
      OUT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == ACCUM) || (state == CHECK);
    result_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc       <= '0;
      count     <= '0;
      sum       <= '0;
      magnitude <= '0;
      seq_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (calc_enable) begin
            acc       <= '0;
            count     <= '0;
            seq_error <= 1'b0;
          end
        end
        ACCUM: begin
          if (calc_done) begin
            seq_error <= 1'b1;
          end else begin
            acc   <= acc + ACC_W'(prod);
            count <= count + 1'b1;
          end
        end
        CHECK: begin
          if (calc_done) begin
            sum       <= acc;
            magnitude <= mag_sat;
          end else begin
            seq_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
